// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator: holds the PC of the current fetch group and picks the next
// one from exception redirect, branch redirect, predictor or sequential sources.
module fetch_pc_gen #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_ADDR  = 32'h0000_0000,
   parameter int unsigned     FETCH_WIDTH = 2,
   parameter int unsigned     EPOCH_W     = 3
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   exc_redirect_valid,
   input  logic [XLEN-1:0]        exc_redirect_pc,
   input  logic                   br_redirect_valid,
   input  logic [XLEN-1:0]        br_redirect_pc,
   input  logic                   pred_taken,
   input  logic [XLEN-1:0]        pred_target,
   input  logic                   halt_req,
   input  logic                   resume_req,
   input  logic                   fetch_ready,
   output logic                   fetch_valid,
   output logic [XLEN-1:0]        fetch_pc,
   output logic [FETCH_WIDTH-1:0] fetch_mask,
   output logic [EPOCH_W-1:0]     fetch_epoch,
   output logic                   halted
);

   localparam int unsigned     GROUP_BYTES = FETCH_WIDTH * 4;
   localparam logic [XLEN-1:0] GROUP_STEP  = XLEN'(GROUP_BYTES);
   localparam logic [XLEN-1:0] GROUP_LOW   = XLEN'(GROUP_BYTES - 1);
   localparam logic [XLEN-1:0] WORD_MASK   = ~XLEN'(2'b11);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } state_e;

   state_e                 state_r;
   state_e                 state_nxt_s;
   logic [XLEN-1:0]        pc_r;
   logic [XLEN-1:0]        pc_nxt_s;
   logic [EPOCH_W-1:0]     epoch_r;
   logic [EPOCH_W-1:0]     epoch_nxt_s;
   logic                   fetch_valid_r;
   logic [FETCH_WIDTH-1:0] fetch_mask_r;
   logic                   halted_r;
   logic                   fire_s;
   logic                   redirect_s;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & WORD_MASK;
   endfunction

   function automatic logic [XLEN-1:0] group_base(input logic [XLEN-1:0] addr);
      return addr & ~GROUP_LOW;
   endfunction

   // Lane i is live when it sits at or after the entry lane of the group.
   function automatic logic [FETCH_WIDTH-1:0] lane_mask(input logic [XLEN-1:0] addr);
      logic [XLEN-1:0]        offset;
      logic [FETCH_WIDTH-1:0] mask;
      offset = (addr & GROUP_LOW) >> 2'd2;
      mask   = {FETCH_WIDTH{1'b0}};
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         mask[i] = (XLEN'(i) >= offset);
      end
      return mask;
   endfunction

   assign fire_s     = fetch_valid_r & fetch_ready;
   assign redirect_s = exc_redirect_valid | br_redirect_valid;

   // Next-state, next-PC and next-epoch selection.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      epoch_nxt_s = epoch_r;
      case (state_r)
         ST_BOOT: begin
            state_nxt_s = ST_RUN;
         end
         ST_RUN, ST_HALTED: begin
            if (exc_redirect_valid) begin
               pc_nxt_s    = align_word(exc_redirect_pc);
               epoch_nxt_s = epoch_r + EPOCH_W'(1'b1);
            end else if (br_redirect_valid) begin
               pc_nxt_s    = align_word(br_redirect_pc);
               epoch_nxt_s = epoch_r + EPOCH_W'(1'b1);
            end else if (fire_s && pred_taken) begin
               pc_nxt_s = align_word(pred_target);
            end else if (fire_s) begin
               pc_nxt_s = group_base(pc_r) + GROUP_STEP;
            end else begin
               pc_nxt_s = pc_r;
            end

            // A fire alongside halt_req still advances the PC above.
            if (redirect_s) begin
               state_nxt_s = ST_RUN;
            end else if ((state_r == ST_RUN) && halt_req) begin
               state_nxt_s = ST_HALTED;
            end else if ((state_r == ST_HALTED) && resume_req) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            state_nxt_s = ST_BOOT;
         end
      endcase
   end

   // State, PC, epoch and the registered output flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_BOOT;
         pc_r          <= RESET_ADDR;
         epoch_r       <= {EPOCH_W{1'b0}};
         fetch_valid_r <= 1'b0;
         fetch_mask_r  <= {FETCH_WIDTH{1'b0}};
         halted_r      <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         pc_r          <= pc_nxt_s;
         epoch_r       <= epoch_nxt_s;
         fetch_valid_r <= (state_nxt_s == ST_RUN);
         fetch_mask_r  <= (state_nxt_s == ST_RUN) ? lane_mask(pc_nxt_s)
                                                  : {FETCH_WIDTH{1'b0}};
         halted_r      <= (state_nxt_s == ST_HALTED);
      end
   end

   assign fetch_valid = fetch_valid_r;
   assign fetch_pc    = pc_r;
   assign fetch_mask  = fetch_mask_r;
   assign fetch_epoch = epoch_r;
   assign halted      = halted_r;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model of the PC/epoch/state rules.
module tb_fetch_pc_gen;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned FW    = 2;
   localparam int unsigned EW    = 3;
   localparam logic [31:0] RADDR = 32'h0000_1000;

   logic          clock;
   logic          reset_n;
   logic          exc_redirect_valid;
   logic [31:0]   exc_redirect_pc;
   logic          br_redirect_valid;
   logic [31:0]   br_redirect_pc;
   logic          pred_taken;
   logic [31:0]   pred_target;
   logic          halt_req;
   logic          resume_req;
   logic          fetch_ready;
   logic          fetch_valid;
   logic [31:0]   fetch_pc;
   logic [FW-1:0] fetch_mask;
   logic [EW-1:0] fetch_epoch;
   logic          halted;

   int n_checks = 0;
   int n_fail   = 0;

   // model: 0 = boot, 1 = run, 2 = halted
   int          m_state;
   logic [31:0] m_pc;
   int          m_epoch;

   fetch_pc_gen #(
      .XLEN(XLEN), .RESET_ADDR(RADDR), .FETCH_WIDTH(FW), .EPOCH_W(EW)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .exc_redirect_valid(exc_redirect_valid), .exc_redirect_pc(exc_redirect_pc),
      .br_redirect_valid(br_redirect_valid), .br_redirect_pc(br_redirect_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .halt_req(halt_req), .resume_req(resume_req), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_mask(fetch_mask),
      .fetch_epoch(fetch_epoch), .halted(halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] model_mask();
      logic [FW-1:0] m;
      int off;
      m   = '0;
      off = int'((m_pc % (FW * 4)) / 4);
      for (int i = 0; i < FW; i++) m[i] = (m_state == 1) && (i >= off);
      return m;
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_pc    = RADDR;
      m_epoch = 0;
   endtask

   task automatic model_edge();
      bit fire;
      bit redir;
      if (m_state == 0) begin
         m_state = 1;
      end else begin
         fire  = (m_state == 1) && fetch_ready;
         redir = exc_redirect_valid || br_redirect_valid;
         if (exc_redirect_valid) begin
            m_pc    = exc_redirect_pc & 32'hFFFF_FFFC;
            m_epoch = (m_epoch + 1) % (1 << EW);
         end else if (br_redirect_valid) begin
            m_pc    = br_redirect_pc & 32'hFFFF_FFFC;
            m_epoch = (m_epoch + 1) % (1 << EW);
         end else if (fire && pred_taken) begin
            m_pc = pred_target & 32'hFFFF_FFFC;
         end else if (fire) begin
            m_pc = 32'(((64'(m_pc) / (FW * 4)) * (FW * 4) + FW * 4) % 64'h1_0000_0000);
         end
         if (redir) m_state = 1;
         else if (m_state == 1 && halt_req) m_state = 2;
         else if (m_state == 2 && resume_req) m_state = 1;
      end
   endtask

   task automatic compare_all();
      check("valid",  64'(fetch_valid), 64'(m_state == 1));
      check("halted", 64'(halted),      64'(m_state == 2));
      check("pc",     64'(fetch_pc),    64'(m_pc));
      check("mask",   64'(fetch_mask),  64'(model_mask()));
      check("epoch",  64'(fetch_epoch), 64'(m_epoch));
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle();
      exc_redirect_valid = 1'b0; exc_redirect_pc = 32'h0;
      br_redirect_valid  = 1'b0; br_redirect_pc  = 32'h0;
      pred_taken = 1'b0; pred_target = 32'h0;
      halt_req = 1'b0; resume_req = 1'b0; fetch_ready = 1'b0;
   endtask

   // Called just after a rising edge: assert reset mid-cycle and check at once.
   task automatic mid_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("rst_valid", 64'(fetch_valid), 64'h0);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      idle();
      reset_n = 1'b0;
      model_reset();
      #12;
      compare_all();
      check("rst_pc", 64'(fetch_pc), 64'h1000);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      #1;
      check("boot_valid", 64'(fetch_valid), 64'h0);
      step();
      check("boot_pc",   64'(fetch_pc),    64'h1000);
      check("boot_mask", 64'(fetch_mask),  64'h3);

      // sequential then backpressure
      fetch_ready = 1'b1;
      step(); check("seq1", 64'(fetch_pc), 64'h1008);
      step(); check("seq2", 64'(fetch_pc), 64'h1010);
      fetch_ready = 1'b0;
      pred_taken = 1'b1; pred_target = 32'hDEAD_0000;
      for (int k = 0; k < 3; k++) begin
         step(); check("stall_pc", 64'(fetch_pc), 64'h1010);
      end
      pred_taken = 1'b0;

      // unaligned branch redirect
      br_redirect_valid = 1'b1; br_redirect_pc = 32'h2006;
      step();
      check("br_pc", 64'(fetch_pc), 64'h2004);
      check("br_mask", 64'(fetch_mask), 64'h2);
      check("br_epoch", 64'(fetch_epoch), 64'h1);
      br_redirect_valid = 1'b0; fetch_ready = 1'b1;
      step();
      check("br_seq_pc", 64'(fetch_pc), 64'h2008);
      check("br_seq_mask", 64'(fetch_mask), 64'h3);

      // priority: exception beats branch beats predictor
      exc_redirect_valid = 1'b1; exc_redirect_pc = 32'h8000;
      br_redirect_valid = 1'b1; br_redirect_pc = 32'h3000;
      pred_taken = 1'b1; pred_target = 32'h4000;
      step();
      check("prio_pc", 64'(fetch_pc), 64'h8000);
      check("prio_epoch", 64'(fetch_epoch), 64'h2);
      idle();

      // epoch wrap
      for (int k = 0; k < 8; k++) begin
         br_redirect_valid = 1'b1; br_redirect_pc = 32'h3000 + 32'(k * 8);
         step();
         check("wrap_epoch", 64'(fetch_epoch), 64'((2 + k + 1) % 8));
      end
      idle();

      // halt / resume
      exc_redirect_valid = 1'b1; exc_redirect_pc = 32'h1000;
      step();
      idle();
      halt_req = 1'b1; fetch_ready = 1'b1;
      step();
      check("halt_pc", 64'(fetch_pc), 64'h1008);
      check("halt_flag", 64'(halted), 64'h1);
      check("halt_valid", 64'(fetch_valid), 64'h0);
      halt_req = 1'b0;
      step();
      check("held_pc", 64'(fetch_pc), 64'h1008);
      resume_req = 1'b1;
      step();
      check("resume_valid", 64'(fetch_valid), 64'h1);
      check("resume_pc", 64'(fetch_pc), 64'h1008);
      resume_req = 1'b0; halt_req = 1'b1; fetch_ready = 1'b0;
      step();
      check("halt2_flag", 64'(halted), 64'h1);
      halt_req = 1'b0; br_redirect_valid = 1'b1; br_redirect_pc = 32'h5000;
      step();
      check("hbr_pc", 64'(fetch_pc), 64'h5000);
      check("hbr_valid", 64'(fetch_valid), 64'h1);
      check("hbr_epoch", 64'(fetch_epoch), 64'h4);

      // address-space wrap
      br_redirect_pc = 32'hFFFF_FFFE;
      step();
      check("top_mask", 64'(fetch_mask), 64'h2);
      br_redirect_valid = 1'b0; fetch_ready = 1'b1;
      step();
      check("top_wrap_pc", 64'(fetch_pc), 64'h0);
      idle();

      mid_reset();
      check("mid_rst_pc", 64'(fetch_pc), 64'h1000);
      step();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         exc_redirect_valid = ($urandom_range(0, 19) == 0);
         exc_redirect_pc    = $urandom();
         br_redirect_valid  = ($urandom_range(0, 9) == 0);
         br_redirect_pc     = ($urandom_range(0, 7) == 0) ?
                              (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
         pred_taken         = ($urandom_range(0, 3) == 0);
         pred_target        = $urandom();
         halt_req           = ($urandom_range(0, 15) == 0);
         resume_req         = ($urandom_range(0, 3) == 0);
         fetch_ready        = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 499) == 0) mid_reset();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
